// File: rtl/fft_pkg.sv
// Shared FFT types: scheduler state codes, twiddle select, the 4-point op schedule
// and complex pack/unpack helpers also used by fft_butterfly.
package fft_pkg;

    localparam int CPLX_W = 32;
    localparam int HALF_W = CPLX_W / 2;

    typedef logic [1:0] sched_state_t;
    localparam sched_state_t IDLE = 2'd0;
    localparam sched_state_t RUN  = 2'd1;
    localparam sched_state_t DONE = 2'd2;

    typedef enum logic {TW_W0 = 1'b0, TW_W1 = 1'b1} tw_sel_t;

    typedef struct packed {
        logic [1:0] a_idx;
        logic [1:0] b_idx;
        tw_sel_t    tw;
    } sched_op_t;

    // In-place radix-2 DIT on bit-reversed working regs: stage 1 then stage 2.
    localparam sched_op_t SCHED_TABLE [4] = '{
        '{2'd0, 2'd1, TW_W0},
        '{2'd2, 2'd3, TW_W0},
        '{2'd0, 2'd2, TW_W0},
        '{2'd1, 2'd3, TW_W1}
    };

    function automatic logic signed [HALF_W-1:0] re(input logic [CPLX_W-1:0] w);
        return w[CPLX_W-1:HALF_W];
    endfunction

    function automatic logic signed [HALF_W-1:0] im(input logic [CPLX_W-1:0] w);
        return w[HALF_W-1:0];
    endfunction

    function automatic logic [CPLX_W-1:0] cplx(input logic signed [HALF_W-1:0] r,
                                                input logic signed [HALF_W-1:0] i);
        return {r, i};
    endfunction

endpackage

// File: rtl/fft4_sched_if.sv
// Request/ack link between the FFT scheduler and the shared butterfly unit.
interface fft4_sched_if #(parameter int WIDTH = 32);
    logic             req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             tw;
    logic             ack;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    modport master (output req, a, b, tw, input ack, x, y);
    modport slave  (input req, a, b, tw, output ack, x, y);
endinterface

// File: rtl/fft4_sched.sv
// 4-point radix-2 DIT FFT sequencer: walks a fixed 4-op schedule over one shared
// butterfly, writing results back in place, then latches the spectrum.
module fft4_sched
    import fft_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0][WIDTH-1:0]   A_In,
    output logic [3:0][WIDTH-1:0]   A_Out,
    output logic                    busy,
    output logic                    done,
    fft4_sched_if.master            bfly
);

    sched_state_t            state;
    logic [1:0]              op;
    logic [3:0][WIDTH-1:0]   r;
    logic [3:0][WIDTH-1:0]   r_wb;
    sched_op_t               cur;

    assign cur = SCHED_TABLE[op];

    // Register file as it will look after the current butterfly result lands.
    always_comb begin
        r_wb             = r;
        r_wb[cur.a_idx]  = bfly.x;
        r_wb[cur.b_idx]  = bfly.y;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            op    <= '0;
            r     <= '0;
            A_Out <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r     <= {A_In[3], A_In[1], A_In[2], A_In[0]};
                        op    <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bfly.ack) begin
                        r  <= r_wb;
                        op <= op + 2'd1;
                        if (op == 2'd3) begin
                            A_Out <= r_wb;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign bfly.req = busy;
    assign bfly.a   = busy ? r[cur.a_idx] : '0;
    assign bfly.b   = busy ? r[cur.b_idx] : '0;
    assign bfly.tw  = busy && (cur.tw == TW_W1);

endmodule

// File: doc/fft4_sched.md
# fft4_sched

Sequencing controller that computes a 4-point radix-2 DIT FFT by time-multiplexing one shared complex butterfly unit. It holds the four complex samples in a working register file, issues the four butterfly operations (two per stage) over a req/ack handshake, writes results back in place, and presents the natural-order spectrum with a done flag. It sits between the sample source and the existing `fft_butterfly` instance, which the parent wires to the `bfly_*` ports.

## Interface
- `WIDTH`, 32: complex word width; bits [WIDTH-1:WIDTH/2] real, [WIDTH/2-1:0] imaginary, both two's complement.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a transform; samples `A_In` on the same edge.
- `A_In[3:0]`  in  WIDTH each  time-domain samples, natural order.
- `A_Out[3:0]`  out  WIDTH each  frequency-domain result, natural order, registered.
- `busy`  out  1  high while a transform is in progress.
- `done`  out  1  high while `A_Out` holds a completed result.
- `bfly_req`  out  1  operands valid, request one butterfly.
- `bfly_a`, `bfly_b`  out  WIDTH  butterfly operands.
- `bfly_tw`  out  1  twiddle select: 0 = W0 (1), 1 = W1 (-j).
- `bfly_ack`  in  1  butterfly results valid this cycle.
- `bfly_x`, `bfly_y`  in  WIDTH  results, x = a + W·b, y = a − W·b.

## Operation
- States: IDLE, RUN, DONE. Op counter `op` is 2 bits, 0..3.
- IDLE: `start` loads working regs in bit-reversed order: r0=A_In[0], r1=A_In[2], r2=A_In[1], r3=A_In[3]; `op`←0; go to RUN.
- Op schedule in RUN: op0 (r0,r1, tw 0); op1 (r2,r3, tw 0); op2 (r0,r2, tw 0); op3 (r1,r3, tw 1). `bfly_a`/`bfly_b` are the first and second registers of the pair.
- RUN: `bfly_req`=1 with operands for `op`. On `bfly_ack`: x written to the first register, y to the second, `op`++. If `op`==3 on ack, copy r0..r3 into A_Out[0..3] and go to DONE.
- DONE: `done`=1, A_Out held. `start` reloads as in IDLE, goes to RUN, and clears `done`. A_Out keeps its old value until the next completion.
- No arithmetic in this block. Width, scaling and overflow handling belong to the butterfly.
- `start` while in RUN is ignored. `bfly_ack` outside RUN is ignored, and `bfly_x`/`bfly_y` are don't-care then.
- `reset` in any state, including mid-RUN with a request outstanding: next state IDLE, and all outputs and working regs go to 0. A late ack after reset is ignored.

## Timing
- Reset values: `A_Out` all 0, `busy`=0, `done`=0, `bfly_req`=0, `bfly_a`=`bfly_b`=0, `bfly_tw`=0.
- `busy` = (state==RUN). `bfly_req`, `bfly_a`, `bfly_b` and `bfly_tw` are decoded from state and `op`, stable while a request is held.
- A request is held until ack. Ack may arrive in the first request cycle, which gives zero wait.
- The next op's request appears the cycle after the ack. Requests are never back-to-back on the same op.
- Latency: start edge at cycle 0; with ack tied high, RUN occupies cycles 1–4 and `done`=1 from cycle 5. Each cycle of ack delay adds one cycle.

## Structure
- Shared package `fft_pkg`: `sched_state_t` (IDLE/RUN/DONE), `tw_sel_t` (TW_W0, TW_W1), and `re()`/`im()`/`cplx()` pack helpers shared with `fft_butterfly`.
- No sub-module. The op schedule is a 4-entry constant table (pair indices plus twiddle) in `fft_pkg`. The butterfly stays a separate `fft_butterfly` instance in the parent.

## Test plan
- Bench model: behavioural butterfly, exact integer arithmetic, no scaling.
- Basic transform: A_In real {1,2,3,4}, imag 0, ack tied high → A_Out = {10, −2+2j, −2, −2−2j}; `done` rises at cycle 5; `busy` is high for cycles 1–4.
- Operand order: with ack delayed 3 cycles per op → requests are (1,3,tw0), (2,4,tw0), (4,6,tw0), (−2,−2,tw1); operands stay stable while waiting; total latency is 17 cycles.
- Impulse: A_In = {1,0,0,0} → A_Out = {1,1,1,1}. Then `start` in DONE with {0,1,0,0} → `done` drops the next cycle, A_Out holds the old value until the new result {1, −j, −1, j}.
- Reset mid-op: assert `reset` while the op2 request is waiting → next cycle all outputs are 0 and the state is IDLE; an ack pulse one cycle later causes no change.
- Spurious inputs: `start` pulses during RUN and `bfly_ack` pulses in IDLE/DONE → no state or output change; the in-flight result is unaffected.
